// File: rtl/bp_stream_to_lite_buffered.sv
// Assembles BP Stream beats into whole BP Lite messages and queues them in a small FIFO.
// Header layout (LSB first): msg_type[3:0], size[6:4], addr, lce_id, way_id.
module bp_stream_to_lite_buffered #(
    parameter int paddr_width_p    = 40,
    parameter int lce_id_width_p   = 4,
    parameter int lce_assoc_p      = 8,
    parameter int in_data_width_p  = 64,
    parameter int out_data_width_p = 512,
    parameter int master_p         = 0,
    parameter int fifo_els_p       = 2,
    localparam int way_id_width_lp = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
    localparam int in_mem_msg_header_width_lp =
        4 + 3 + paddr_width_p + lce_id_width_p + way_id_width_lp,
    localparam int out_mem_msg_width_lp = in_mem_msg_header_width_lp + out_data_width_p
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic [in_mem_msg_header_width_lp-1:0] mem_header_i,
    input  logic [in_data_width_p-1:0]            mem_data_i,
    input  logic                                  mem_v_i,
    output logic                                  mem_ready_o,
    output logic [out_mem_msg_width_lp-1:0]       mem_o,
    output logic                                  mem_v_o,
    input  logic                                  mem_yumi_i
);

    localparam int stream_words_lp = out_data_width_p / in_data_width_p;
    localparam int in_bytes_lp     = in_data_width_p / 8;
    localparam int out_bytes_lp    = out_data_width_p / 8;
    localparam int cnt_width_lp    = (stream_words_lp > 1) ? $clog2(stream_words_lp) : 1;
    localparam int ptr_width_lp    = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int occ_width_lp    = $clog2(fifo_els_p + 1);
    localparam int hdr_w_lp        = in_mem_msg_header_width_lp;

    localparam logic [3:0] e_mem_msg_wr    = 4'd1;
    localparam logic [3:0] e_mem_msg_uc_wr = 4'd3;

    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(fifo_els_p - 1);
    localparam logic [occ_width_lp-1:0] full_occ_lp = occ_width_lp'(fifo_els_p);

    typedef enum logic {
        e_idle,
        e_collect
    } state_e;

    state_e                         state_r, state_n;
    logic [cnt_width_lp-1:0]        cnt_r, cnt_n;
    logic [hdr_w_lp-1:0]            hdr_r;
    logic [out_data_width_p-1:0]    lanes_r;
    logic                           ready_en_r;

    logic [hdr_w_lp-1:0]            act_hdr;
    logic [cnt_width_lp:0]          beats;
    logic                           last_beat;
    logic                           accept;
    logic                           push;
    logic                           pop;
    logic                           fifo_full;
    logic [cnt_width_lp-1:0]        lane_idx;
    logic [out_data_width_p-1:0]    assembled;
    logic [out_data_width_p-1:0]    payload;
    int                             size_bytes;
    int                             rep_bytes;

    logic [out_mem_msg_width_lp-1:0] fifo_mem [fifo_els_p];
    logic [ptr_width_lp-1:0]         rd_ptr_r, wr_ptr_r;
    logic [occ_width_lp-1:0]         occ_r;

    function automatic logic carries_payload(input logic [hdr_w_lp-1:0] hdr);
        logic is_wr;
        is_wr = (hdr[3:0] == e_mem_msg_wr) || (hdr[3:0] == e_mem_msg_uc_wr);
        return is_wr ^ (master_p != 0);
    endfunction

    function automatic logic [cnt_width_lp:0] calc_beats(input logic [hdr_w_lp-1:0] hdr);
        int b;
        b = 1;
        if (carries_payload(hdr)) begin
            b = int'(32'd1 << hdr[6:4]) / in_bytes_lp;
            if (b < 1) b = 1;
            if (b > stream_words_lp) b = stream_words_lp;
        end
        return (cnt_width_lp + 1)'(b);
    endfunction

    function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + 1'b1;
    endfunction

    // While idle the incoming beat's header decides the message shape; afterwards the captured one does.
    assign act_hdr   = (state_r == e_idle) ? mem_header_i : hdr_r;
    assign beats     = calc_beats(act_hdr);
    assign last_beat = (state_r == e_idle) ? (beats == 1)
                                           : ({1'b0, cnt_r} == beats - 1'b1);
    assign fifo_full   = (occ_r == full_occ_lp);
    assign mem_ready_o = ready_en_r & ~(last_beat & fifo_full);
    assign accept      = mem_v_i & mem_ready_o;
    assign push        = accept & last_beat;
    assign pop         = mem_yumi_i & (occ_r != '0);

    // A new message starts from zeroed lanes so nothing from an earlier message leaks through.
    always_comb begin
        assembled = (state_r == e_idle) ? '0 : lanes_r;
        lane_idx  = (state_r == e_idle) ? '0 : cnt_r;
        assembled[lane_idx*in_data_width_p +: in_data_width_p] = mem_data_i;
    end

    // Small messages are replicated across the full payload; dataless messages carry zeros.
    always_comb begin
        size_bytes = int'(32'd1 << act_hdr[6:4]);
        rep_bytes  = (size_bytes < in_bytes_lp) ? in_bytes_lp : size_bytes;
        payload    = assembled;
        if (!carries_payload(act_hdr)) begin
            payload = '0;
        end else if (size_bytes < out_bytes_lp) begin
            for (int i = 0; i < out_bytes_lp; i++) begin
                payload[8*i +: 8] = assembled[8*(i & (rep_bytes - 1)) +: 8];
            end
        end
    end

    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        if (accept) begin
            if (last_beat) begin
                state_n = e_idle;
                cnt_n   = '0;
            end else if (state_r == e_idle) begin
                state_n = e_collect;
                cnt_n   = cnt_width_lp'(1);
            end else begin
                cnt_n = cnt_r + 1'b1;
            end
        end
    end

    // Acceptance is held off for one cycle after reset release.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= e_idle;
            cnt_r      <= '0;
            hdr_r      <= '0;
            lanes_r    <= '0;
            ready_en_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            ready_en_r <= 1'b1;
            if (accept && state_r == e_idle) hdr_r <= mem_header_i;
            if (accept) lanes_r <= assembled;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            occ_r    <= '0;
        end else begin
            if (push) wr_ptr_r <= next_ptr(wr_ptr_r);
            if (pop)  rd_ptr_r <= next_ptr(rd_ptr_r);
            if (push && !pop)      occ_r <= occ_r + 1'b1;
            else if (!push && pop) occ_r <= occ_r - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_r] <= {act_hdr, payload};
    end

    assign mem_o   = fifo_mem[rd_ptr_r];
    assign mem_v_o = (occ_r != '0);

endmodule

// File: tb/tb_bp_stream_to_lite_buffered.sv
// Bench for bp_stream_to_lite_buffered: one instance per master_p value, each checked every cycle against a queue model.
module tb_bp_stream_to_lite_buffered;

    localparam int IN_W  = 64;
    localparam int OUT_W = 512;
    localparam int HDR_W = 54;
    localparam int MSG_W = HDR_W + OUT_W;
    localparam int FIFO  = 2;

    logic clk = 1'b0;
    logic rst_n;

    logic [HDR_W-1:0] hdr_in   [2];
    logic [IN_W-1:0]  data_in  [2];
    logic             v_in     [2];
    logic             ready_out[2];
    logic [MSG_W-1:0] msg_out  [2];
    logic             v_out    [2];
    logic             yumi_in  [2];

    int checks = 0;
    int failures = 0;
    int yumi_mode [2] = '{0, 0};
    int pulse_req [2] = '{0, 0};
    int pulse_done[2] = '{0, 0};

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [MSG_W-1:0] act,
                                input logic [MSG_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic bit carries(input logic [HDR_W-1:0] h, input int master);
        bit is_wr;
        is_wr = (h[3:0] == 4'd1) || (h[3:0] == 4'd3);
        return is_wr ^ (master != 0);
    endfunction

    function automatic int beats_for(input logic [HDR_W-1:0] h, input int master);
        int b;
        if (!carries(h, master)) return 1;
        b = (1 << h[6:4]) / 8;
        if (b < 1) b = 1;
        if (b > 8) b = 8;
        return b;
    endfunction

    // Payload expected from the message rules: zeros, replicated low bytes, or all beats in order.
    function automatic logic [OUT_W-1:0] model_payload(input logic [HDR_W-1:0] h, input int master,
                                                       input logic [63:0] beats[$]);
        logic [OUT_W-1:0] flat;
        logic [OUT_W-1:0] res;
        int sb;
        int rep;
        flat = '0;
        res  = '0;
        foreach (beats[k]) flat[64*k +: 64] = beats[k];
        if (!carries(h, master)) return '0;
        sb = 1 << h[6:4];
        if (sb >= 64) return flat;
        rep = (sb < 8) ? 8 : sb;
        for (int i = 0; i < 64; i++) res[8*i +: 8] = flat[8*(i % rep) +: 8];
        return res;
    endfunction

    function automatic logic [HDR_W-1:0] make_hdr(input int t, input int s,
                                                  input logic [39:0] addr, input logic [6:0] pl);
        return {pl, addr, 3'(s), 4'(t)};
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bp_stream_to_lite_buffered #(
            .in_data_width_p (IN_W),
            .out_data_width_p(OUT_W),
            .master_p        (g),
            .fifo_els_p      (FIFO)
        ) dut (
            .clk_i       (clk),
            .reset_n_i   (rst_n),
            .mem_header_i(hdr_in[g]),
            .mem_data_i  (data_in[g]),
            .mem_v_i     (v_in[g]),
            .mem_ready_o (ready_out[g]),
            .mem_o       (msg_out[g]),
            .mem_v_o     (v_out[g]),
            .mem_yumi_i  (yumi_in[g])
        );

        // Consumer: yumi only while a message is offered.
        initial begin
            yumi_in[g] = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                case (yumi_mode[g])
                    1:       yumi_in[g] = v_out[g] && ($urandom_range(0, 1) == 1);
                    2:       yumi_in[g] = v_out[g];
                    default: yumi_in[g] = 1'b0;
                endcase
                if (pulse_req[g] != pulse_done[g] && v_out[g]) begin
                    yumi_in[g] = 1'b1;
                    pulse_done[g]++;
                end
            end
        end

        // Reference model and per-cycle compare.
        initial begin : model
            logic [MSG_W-1:0] exp_q[$];
            logic [63:0]      beat_q[$];
            logic [HDR_W-1:0] cur_hdr;
            int               need;
            bit               ready_en;
            bit               last;
            bit               exp_ready;
            bit               acc;
            bit               pop;
            ready_en = 0;
            need     = 1;
            cur_hdr  = '0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    check_output($sformatf("m%0d_reset_valid", g), MSG_W'(v_out[g]), '0);
                    check_output($sformatf("m%0d_reset_ready", g), MSG_W'(ready_out[g]), '0);
                    exp_q.delete();
                    beat_q.delete();
                    ready_en = 0;
                    continue;
                end
                if (beat_q.size() == 0) last = (beats_for(hdr_in[g], g) == 1);
                else                    last = (beat_q.size() + 1 == need);
                exp_ready = ready_en && !(last && exp_q.size() == FIFO);
                check_output($sformatf("m%0d_ready", g), MSG_W'(ready_out[g]), MSG_W'(exp_ready));
                check_output($sformatf("m%0d_valid", g), MSG_W'(v_out[g]),
                             MSG_W'(exp_q.size() != 0));
                if (exp_q.size() != 0)
                    check_output($sformatf("m%0d_msg", g), msg_out[g], exp_q[0]);
                acc = v_in[g] && ready_out[g];
                pop = yumi_in[g] && (exp_q.size() != 0);
                @(posedge clk);
                if (!rst_n) continue;
                ready_en = 1;
                if (pop) void'(exp_q.pop_front());
                if (acc) begin
                    if (beat_q.size() == 0) begin
                        cur_hdr = hdr_in[g];
                        need    = beats_for(cur_hdr, g);
                    end
                    beat_q.push_back(data_in[g]);
                    if (beat_q.size() == need) begin
                        exp_q.push_back({cur_hdr, model_payload(cur_hdr, g, beat_q)});
                        beat_q.delete();
                    end
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input int d);
        int  t;
        bit  took;
        t    = 0;
        took = 0;
        while (!took) begin
            @(negedge clk);
            took = ready_out[d];
            sync();
            t++;
            if (!took && t > 200) begin
                check_output($sformatf("m%0d_accept_timeout", d), '0, MSG_W'(1));
                break;
            end
        end
    endtask

    task automatic send_msg(input int d, input logic [HDR_W-1:0] h, input logic [63:0] dat[8],
                            input int nb, input bit scramble);
        logic [63:0] r;
        for (int k = 0; k < nb; k++) begin
            r          = rand64();
            v_in[d]    = 1'b1;
            hdr_in[d]  = (k == 0 || !scramble) ? h : r[HDR_W-1:0];
            data_in[d] = dat[k];
            wait_accept(d);
        end
        v_in[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int t;
        yumi_mode[d] = 2;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (v_out[d] && t < 50);
        if (v_out[d]) check_output($sformatf("m%0d_drain_timeout", d), MSG_W'(v_out[d]), '0);
        yumi_mode[d] = 0;
        sync();
    endtask

    task automatic random_traffic(input int d, input int n);
        logic [63:0]      dat[8];
        logic [HDR_W-1:0] h;
        logic [63:0]      a;
        for (int m = 0; m < n; m++) begin
            a = rand64();
            h = make_hdr($urandom_range(0, 3), $urandom_range(0, 7), a[39:0], a[46:40]);
            for (int k = 0; k < 8; k++) dat[k] = rand64();
            send_msg(d, h, dat, beats_for(h, d), 1'b1);
            if ($urandom_range(0, 3) == 0) sync();
        end
    endtask

    initial begin
        logic [63:0]      dat[8];
        logic [HDR_W-1:0] h;
        logic [HDR_W-1:0] h2;

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            hdr_in[d]  = '0;
            data_in[d] = '0;
            v_in[d]    = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_valid_low", MSG_W'(v_out[0]), '0);
        check_output("reset_ready_low", MSG_W'(ready_out[0]), '0);
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        check_output("ready_before_first_edge", MSG_W'(ready_out[0]), '0);
        sync();
        @(negedge clk);
        check_output("ready_after_first_edge", MSG_W'(ready_out[0]), MSG_W'(1));
        sync();

        // 64B write: lanes 0..7 in order.
        h = make_hdr(1, 6, 40'h00_0000_1000, 7'h11);
        for (int k = 0; k < 8; k++) dat[k] = 64'(k);
        send_msg(0, h, dat, 8, 1'b0);
        check_output("wr64_valid", MSG_W'(v_out[0]), MSG_W'(1));
        check_output("wr64_data", MSG_W'(msg_out[0][OUT_W-1:0]),
                     MSG_W'({64'h7, 64'h6, 64'h5, 64'h4, 64'h3, 64'h2, 64'h1, 64'h0}));
        check_output("wr64_header", MSG_W'(msg_out[0][MSG_W-1:OUT_W]), MSG_W'(h));
        drain(0);

        // Read command: one beat, zero data.
        h = make_hdr(0, 6, 40'h00_0000_2040, 7'h22);
        dat[0] = 64'h1234_5678_9ABC_DEF0;
        send_msg(0, h, dat, 1, 1'b0);
        check_output("rd_cmd", msg_out[0], {h, 512'h0});
        drain(0);

        // 8B write: single word replicated.
        h = make_hdr(1, 3, 40'h00_0000_3008, 7'h33);
        dat[0] = 64'hDEAD_BEEF_0123_4567;
        send_msg(0, h, dat, 1, 1'b0);
        check_output("wr8_data", MSG_W'(msg_out[0][OUT_W-1:0]),
                     MSG_W'({8{64'hDEAD_BEEF_0123_4567}}));
        drain(0);

        // Backpressure: two messages fill the buffer, third stalls on its final beat.
        for (int m = 0; m < 2; m++) begin
            h = make_hdr(1, 6, 40'(m * 64), 7'(m));
            for (int k = 0; k < 8; k++) dat[k] = 64'(m * 16 + k);
            send_msg(0, h, dat, 8, 1'b0);
        end
        h = make_hdr(1, 6, 40'h80, 7'h2);
        for (int k = 0; k < 8; k++) dat[k] = 64'(32 + k);
        fork
            send_msg(0, h, dat, 8, 1'b0);
            begin
                repeat (10) @(negedge clk);
                check_output("bp_stall_ready", MSG_W'(ready_out[0]), '0);
                check_output("bp_stall_head", MSG_W'(msg_out[0][63:0]), MSG_W'(64'h0));
                pulse_req[0]++;
                @(negedge clk);
                check_output("bp_ready_yumi_cycle", MSG_W'(ready_out[0]), '0);
                @(negedge clk);
                check_output("bp_ready_after_pop", MSG_W'(ready_out[0]), MSG_W'(1));
                check_output("bp_second_head", MSG_W'(msg_out[0][63:0]), MSG_W'(64'h10));
            end
        join
        drain(0);

        // Reset mid-message with a message already buffered.
        h = make_hdr(0, 6, 40'h500, 7'h44);
        send_msg(0, h, dat, 1, 1'b0);
        h = make_hdr(1, 6, 40'h540, 7'h45);
        for (int k = 0; k < 8; k++) dat[k] = 64'hAAAA_0000 + 64'(k);
        send_msg(0, h, dat, 3, 1'b0);
        check_output("pre_reset_valid", MSG_W'(v_out[0]), MSG_W'(1));
        rst_n = 1'b0;
        #1;
        check_output("reset_async_valid", MSG_W'(v_out[0]), '0);
        check_output("reset_async_ready", MSG_W'(ready_out[0]), '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sync();
        h2 = make_hdr(0, 6, 40'h600, 7'h46);
        dat[0] = 64'h5555_5555_5555_5555;
        send_msg(0, h2, dat, 1, 1'b0);
        check_output("post_reset_msg", msg_out[0], {h2, 512'h0});
        drain(0);

        // Responder side: read response carries 8 beats, write ack carries none.
        h = make_hdr(0, 6, 40'h700, 7'h50);
        for (int k = 0; k < 8; k++) dat[k] = 64'h100 + 64'(k);
        send_msg(1, h, dat, 8, 1'b0);
        check_output("m1_rd_resp", msg_out[1],
                     {h, 64'h107, 64'h106, 64'h105, 64'h104, 64'h103, 64'h102, 64'h101, 64'h100});
        drain(1);
        h = make_hdr(1, 6, 40'h740, 7'h51);
        dat[0] = 64'hABCD;
        send_msg(1, h, dat, 1, 1'b0);
        check_output("m1_wr_ack", msg_out[1], {h, 512'h0});
        drain(1);

        // Random traffic on both instances with random consumer stalls.
        yumi_mode[0] = 1;
        yumi_mode[1] = 1;
        fork
            random_traffic(0, 150);
            random_traffic(1, 150);
        join
        drain(0);
        drain(1);

        repeat (3) sync();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("[TB] FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
